// File: rtl/baby_runctrl.sv
// Run/step/halt controller for a small stored-program processor: divides the
// clock into processor-enable pulses and counts completed instructions.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for run_sw or a step press; no enables
// RUN   | free-running; stops only at the end of stage 3
// STEP  | one full four-stage instruction, then back to IDLE
// HALT  | processor executed STOP; waits for stopsig low or clear
// CLR   | two-cycle processor reset; instruction counter cleared
module baby_runctrl #(
    parameter int DIV   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             clear_btn,
    input  logic             initsig,
    input  logic             stopsig,
    input  logic [1:0]       stepsig,
    output logic             proc_enable,
    output logic             proc_reset,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        HALT,
        CLR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             step_prev;
    logic             clear_prev;
    logic             clr_second;
    logic             step_edge;
    logic             clear_edge;
    logic             last_stage;

    assign step_edge  = step_btn & ~step_prev;
    assign clear_edge = clear_btn & ~clear_prev;

    assign running     = (state == RUN) || (state == STEP);
    assign halted      = (state == HALT);
    assign proc_reset  = (state == CLR);
    assign proc_enable = running && (div_cnt == DIV_LAST);
    assign last_stage  = proc_enable && (stepsig == 2'd3);

    always_comb begin
        state_next = state;
        if (clear_edge) begin
            state_next = CLR;
        end else begin
            case (state)
                IDLE: begin
                    if (stopsig)        state_next = HALT;
                    else if (run_sw)    state_next = RUN;
                    else if (step_edge) state_next = STEP;
                end
                RUN: begin
                    if (stopsig)                    state_next = HALT;
                    else if (last_stage && !run_sw) state_next = IDLE;
                end
                STEP: begin
                    if (stopsig)         state_next = HALT;
                    else if (last_stage) state_next = IDLE;
                end
                HALT: begin
                    if (!stopsig) state_next = IDLE;
                end
                // The processor reset pulse is never cut short by stopsig.
                CLR: begin
                    if (clr_second) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            step_prev   <= 1'b1;
            clear_prev  <= 1'b1;
            clr_second  <= 1'b0;
            instr_count <= '0;
        end else begin
            state      <= state_next;
            step_prev  <= step_btn;
            clear_prev <= clear_btn;
            // A fresh clear edge while already in CLR restarts the two-cycle pulse.
            clr_second <= (state == CLR) && !clear_edge && !clr_second;

            if ((state_next == RUN || state_next == STEP) && state_next == state)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;

            if (state == CLR)
                instr_count <= '0;
            else if (last_stage && !initsig)
                instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: doc/baby_runctrl.md
BABY_RUNCTRL -- requirements
Module: baby_runctrl

Interface
REQ-001 Parameter DIV, 1, run-rate divider: one processor-enable pulse every DIV clocks (DIV >= 1).
REQ-002 Parameter CNT_W, 16, width of the executed-instruction counter.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run_sw  in  1  level; 1 = free-run requested.
REQ-006 step_btn  in  1  synchronous; rising edge = one-instruction request.
REQ-007 clear_btn  in  1  synchronous; rising edge = clear/restart processor.
REQ-008 initsig  in  1  processor is in program-load phase.
REQ-009 stopsig  in  1  processor has executed STOP.
REQ-010 stepsig  in  2  processor's current stage, 0..3.
REQ-011 proc_enable  out  1  processor clock-enable pulse.
REQ-012 proc_reset  out  1  processor reset.
REQ-013 running  out  1  high in RUN or STEP.
REQ-014 halted  out  1  high in HALT.
REQ-015 instr_count  out  CNT_W  completed instructions since the last clear.

Function
REQ-016 FSM states SHALL be IDLE, RUN, STEP, HALT and CLR.
REQ-017 Edge detect: each button SHALL register its previous value; edge = current high and previous low.
REQ-018 Divider div_cnt SHALL run 0..DIV-1 in RUN and STEP only, and SHALL load 0 on entry to either state.
REQ-019 proc_enable = (state RUN or STEP) and div_cnt == DIV-1; with DIV=1 this is every cycle.
REQ-020 Priority, every state: clear edge > stopsig > remaining transitions.
REQ-021 A clear edge in any state SHALL go to CLR.
REQ-022 CLR: proc_reset high for exactly 2 cycles; proc_enable 0; instr_count cleared; then IDLE.
REQ-023 IDLE transitions: stopsig high -> HALT; else run_sw high -> RUN; else step edge -> STEP.
REQ-024 RUN: run_sw low at a cycle with proc_enable high and stepsig == 3 -> IDLE next cycle.
REQ-025 Stopping therefore always occurs at an instruction boundary, and run_sw low at any other stage SHALL NOT stop pulsing early.
REQ-026 STEP: a cycle with proc_enable high and stepsig == 3 -> IDLE next cycle, giving exactly one four-stage cycle.
REQ-027 During initsig, one step SHALL copy one program row.
REQ-028 A step edge in RUN, STEP, HALT or CLR SHALL be ignored and SHALL NOT be queued.
REQ-029 stopsig high in RUN or STEP -> HALT next cycle; no proc_enable in the HALT cycles.
REQ-030 HALT: exit on clear edge -> CLR, or on stopsig low -> IDLE; run_sw and step edges SHALL be ignored.
REQ-031 instr_count SHALL increment in a cycle with proc_enable high, stepsig == 3 and initsig low.
REQ-032 instr_count SHALL wrap modulo 2^CNT_W without a flag.
REQ-033 running = RUN or STEP; halted = HALT; both SHALL be decoded from registered state only.

Reset
REQ-034 reset high SHALL force: state IDLE, div_cnt 0, instr_count 0, proc_enable 0, proc_reset 0, running 0, halted 0.
REQ-035 reset high SHALL load 1 into both button previous-value registers, so a button held through reset produces no edge.
REQ-036 reset SHALL override every other input, including mid-RUN and mid-CLR.

Verification (bench models the processor: stepsig advances 0..3 on each proc_enable; stopsig per scenario)
REQ-037 DIV=1, run_sw=1 for 40 cycles -> proc_enable high every RUN cycle; instr_count = number of stepsig==3 pulses (about 10).
REQ-038 run_sw=0, one step_btn edge -> exactly 4 proc_enable cycles; running high for 4 cycles; instr_count +1; state IDLE.
REQ-039 RUN with run_sw dropped while stepsig==1 -> 3 further enables (stages 1, 2, 3), then none; state IDLE.
REQ-040 stopsig raised in RUN -> proc_enable 0 from the next cycle; halted=1; step edge ignored; clear edge -> proc_reset high 2 cycles, instr_count 0, then IDLE.
REQ-041 DIV=3, RUN -> enables exactly 3 cycles apart; step gives 4 enables over 12 cycles.
REQ-042 step_btn held high across reset deassertion -> no STEP entry; a later release and re-press -> one step.
